// File: rtl/datapath_controller.sv
// Moore controller for the simple datapath: latches one instruction on s in WAIT,
// then steps through register reads, ALU and writeback strobes for that instruction.
module datapath_controller #(
  parameter bit SX_IMM8 = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic        vsel,
  output logic [15:0] datapath_in,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_CALC, S_WREG
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_t;

  state_t r_state, w_next;
  instr_t r_ir;

  logic w_is_movi, w_is_movr, w_is_alu, w_is_mvn, w_is_cmp;

  assign w_is_movi = (r_ir.opcode == 3'b110) && (r_ir.op == 2'b10);
  assign w_is_movr = (r_ir.opcode == 3'b110) && (r_ir.op == 2'b00);
  assign w_is_alu  = (r_ir.opcode == 3'b101);
  assign w_is_mvn  = w_is_alu && (r_ir.op == 2'b11);
  assign w_is_cmp  = w_is_alu && (r_ir.op == 2'b01);

  // imm8 occupies the low byte, overlapping Rd/sh/Rm
  assign datapath_in = SX_IMM8 ? {{8{r_ir.rd[2]}}, r_ir[7:0]} : {8'h00, r_ir[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && s) r_ir <= instr_t'(in);
    end
  end

  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    err      = 1'b0;
    vsel     = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_movi)                  w_next = S_WIMM;
        else if (w_is_movr || w_is_mvn) w_next = S_GETB;
        else if (w_is_alu)              w_next = S_GETA;
        else begin
          w_next = S_WAIT;
          err    = 1'b1;
        end
      end
      S_WIMM: begin
        vsel     = 1'b1;
        writenum = r_ir.rn;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      S_GETA: begin
        readnum = r_ir.rn;
        loada   = 1'b1;
        w_next  = S_GETB;
      end
      S_GETB: begin
        readnum = r_ir.rm;
        loadb   = 1'b1;
        w_next  = S_CALC;
      end
      S_CALC: begin
        shift = r_ir.sh;
        // MOV-register passes B through the adder with A forced to zero
        asel  = w_is_movr;
        ALUop = w_is_movr ? 2'b00 : r_ir.op;
        if (w_is_cmp) begin
          loads  = 1'b1;
          w_next = S_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = S_WREG;
        end
      end
      S_WREG: begin
        vsel     = 1'b0;
        writenum = r_ir.rd;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: per-instruction strobe schedule model checked every
// cycle, a small datapath model driven by the DUT strobes, and literal expectations.
module tb_datapath_controller;

  logic        clk = 1'b0, reset_n = 1'b0, s = 1'b0;
  logic [15:0] in_v = '0;

  logic        w, err, vsel, write, loada, loadb, asel, bsel, loadc, loads;
  logic [15:0] dpin;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, aluop;

  logic        z_w, z_err, z_vsel, z_write, z_loada, z_loadb, z_asel, z_bsel, z_loadc, z_loads;
  logic [15:0] z_dpin;
  logic [2:0]  z_readnum, z_writenum;
  logic [1:0]  z_shift, z_aluop;

  datapath_controller #(.SX_IMM8(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in_v), .w(w), .err(err), .vsel(vsel),
    .datapath_in(dpin), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(aluop), .loadc(loadc), .loads(loads));

  datapath_controller #(.SX_IMM8(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in_v), .w(z_w), .err(z_err), .vsel(z_vsel),
    .datapath_in(z_dpin), .readnum(z_readnum), .writenum(z_writenum), .write(z_write),
    .loada(z_loada), .loadb(z_loadb), .asel(z_asel), .bsel(z_bsel), .shift(z_shift),
    .ALUop(z_aluop), .loadc(z_loadc), .loads(z_loads));

  always #5 clk = ~clk;

  typedef struct packed {
    logic w, err, vsel;
    logic [2:0] rn, wn;
    logic write, loada, loadb, asel, bsel;
    logic [1:0] shift, alu;
    logic loadc, loads;
  } ctl_t;

  ctl_t        q[$];
  logic [15:0] m_ir = '0;
  int          n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.w = 1'b1;
    return c;
  endfunction

  // Expected strobes for every busy cycle of one instruction, derived from its fields
  function automatic void sched(input logic [15:0] ir);
    logic [2:0] opc = ir[15:13], rn = ir[10:8], rd = ir[7:5], rm = ir[2:0];
    logic [1:0] op = ir[12:11], sh = ir[4:3];
    bit   legal = (opc == 3'b110 && (op == 2'b10 || op == 2'b00)) || opc == 3'b101;
    bit   cmp   = (opc == 3'b101 && op == 2'b01);
    ctl_t c = '0;
    c.err = !legal;
    q.push_back(c);
    if (!legal) return;
    if (opc == 3'b110 && op == 2'b10) begin
      c = '0; c.vsel = 1; c.wn = rn; c.write = 1; q.push_back(c);
      return;
    end
    if (opc == 3'b101 && op != 2'b11) begin
      c = '0; c.rn = rn; c.loada = 1; q.push_back(c);
    end
    c = '0; c.rn = rm; c.loadb = 1; q.push_back(c);
    c = '0; c.shift = sh;
    if (opc == 3'b110) begin c.asel = 1; c.alu = 2'b00; end
    else c.alu = op;
    if (cmp) c.loads = 1; else c.loadc = 1;
    q.push_back(c);
    if (!cmp) begin
      c = '0; c.wn = rd; c.write = 1; q.push_back(c);
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_ir <= '0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (s) begin
      m_ir <= in_v;
      sched(in_v);
    end
  end

  always @(negedge clk) begin : cmp_p
    ctl_t e, a;
    e = (q.size() != 0) ? q[0] : idle();
    a = {w, err, vsel, readnum, writenum, write, loada, loadb, asel, bsel, shift, aluop, loadc, loads};
    chk("ctl", 32'(a), 32'(e));
    chk("dpin_sx", 32'(dpin), 32'({{8{m_ir[7]}}, m_ir[7:0]}));
    chk("dpin_zx", 32'(z_dpin), 32'({8'h00, m_ir[7:0]}));
  end

  // Datapath driven by the DUT strobes; applied mid-cycle while strobes are stable
  logic [15:0] rf [8];
  logic [15:0] ra = '0, rb = '0, rc = '0;
  logic [15:0] bs, ain, bin, res;

  always_comb begin
    bs = rb;
    case (shift)
      2'b01:   bs = {rb[14:0], 1'b0};
      2'b10:   bs = {1'b0, rb[15:1]};
      2'b11:   bs = {rb[15], rb[15:1]};
      default: bs = rb;
    endcase
    ain = asel ? 16'h0 : ra;
    bin = bsel ? {11'h0, dpin[4:0]} : bs;
    case (aluop)
      2'b00:   res = ain + bin;
      2'b01:   res = ain - bin;
      2'b10:   res = ain & bin;
      default: res = ~bin;
    endcase
  end

  always @(negedge clk) begin
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= res;
    if (write) rf[writenum] <= vsel ? dpin : rc;
  end

  task automatic run(input logic [15:0] ir, input int exp_lat, input int exp_wr,
                     input int exp_err, input string nm);
    int lat = 0, wr = 0, er = 0;
    bit done = 0;
    @(negedge clk); in_v = ir; s = 1'b1;
    @(negedge clk); s = 1'b0; in_v = 16'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (w) begin done = 1; break; end
      lat++;
      if (write) wr++;
      if (err) er++;
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_writes"}, wr, exp_wr);
    chk({nm, "_errs"}, er, exp_err);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    @(negedge clk);
    chk("rst_w", 32'(w), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_dpin", 32'(dpin), 32'h0);
    #1 reset_n = 1'b1;

    run(16'hD007, 2, 1, 0, "movi_r0");
    chk("r0", 32'(rf[0]), 32'h0007);
    chk("dpin_7", 32'(dpin), 32'h0007);
    run(16'hD1FE, 2, 1, 0, "movi_r1");
    chk("r1", 32'(rf[1]), 32'hFFFE);
    chk("dpin_sx_fe", 32'(dpin), 32'hFFFE);
    chk("dpin_zx_fe", 32'(z_dpin), 32'h00FE);
    run(16'hA148, 5, 1, 0, "add");
    chk("r2_add", 32'(rf[2]), 32'h000C);
    run(16'hA800, 4, 0, 0, "cmp");
    run(16'hB860, 4, 1, 0, "mvn");
    chk("r3_mvn", 32'(rf[3]), 32'hFFF8);
    run(16'hC081, 4, 1, 0, "movr");
    chk("r4_movr", 32'(rf[4]), 32'hFFFE);
    run(16'hE000, 1, 0, 1, "ill_111");
    run(16'hC800, 1, 0, 1, "ill_110_01");
    run(16'hA121, 5, 1, 0, "add_same");
    chk("r1_same", 32'(rf[1]), 32'hFFFC);

    // s held high: second MOV accepted on the first WAIT cycle after the first completes
    @(negedge clk); in_v = 16'hD203; s = 1'b1;
    @(negedge clk); in_v = 16'hD305;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_wait", 32'(w), 32'd1);
    @(negedge clk); s = 1'b0;
    chk("b2b_busy", 32'(w), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_r2", 32'(rf[2]), 32'h0003);
    chk("b2b_r3", 32'(rf[3]), 32'h0005);

    // reset while in GETA aborts the ADD
    @(negedge clk); in_v = 16'hA148; s = 1'b1;
    @(negedge clk); s = 1'b0;
    @(negedge clk);
    chk("geta_loada", 32'(loada), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_w", 32'(w), 32'd1);
    chk("abort_write", 32'(write), 32'd0);
    chk("abort_loada", 32'(loada), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(w), 32'd1);
    #1;
    chk("abort_r2", 32'(rf[2]), 32'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
